// File: rtl/memgame_pkg.sv
// Shared types and helpers for the memory-game pattern sequencer.
package memgame_pkg;

    localparam int DEF_SYMBOL_W  = 3;
    localparam int DEF_MAX_LEN   = 25;
    // Widest symbol the onehot helper decodes; callers truncate to 2**SYMBOL_W.
    localparam int ONEHOT_MAX_W  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW_ON  = 2'd1,
        SHOW_GAP = 2'd2,
        COLLECT  = 2'd3
    } seq_state_t;

    function automatic logic [2**ONEHOT_MAX_W-1:0] onehot(input logic [ONEHOT_MAX_W-1:0] sym);
        onehot      = '0;
        onehot[sym] = 1'b1;
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Control, player-input and status bundle between the mode FSMs and the sequencer.
interface pattern_sequencer_if #(
    parameter int SYMBOL_W = 3,
    parameter int LEN_W    = 5
);
    logic                   clear;
    logic                   start;
    logic                   mode_reverse;
    logic [SYMBOL_W-1:0]    rand_sym;
    logic                   in_valid;
    logic [SYMBOL_W-1:0]    in_sym;
    logic [2**SYMBOL_W-1:0] led;
    logic                   busy;
    logic                   expecting;
    logic                   round_ok;
    logic                   mismatch;
    logic                   timeout;
    logic                   full;
    logic [LEN_W-1:0]       len;

    modport master (
        output clear, start, mode_reverse, rand_sym, in_valid, in_sym,
        input  led, busy, expecting, round_ok, mismatch, timeout, full, len
    );

    modport slave (
        input  clear, start, mode_reverse, rand_sym, in_valid, in_sym,
        output led, busy, expecting, round_ok, mismatch, timeout, full, len
    );
endinterface

// File: rtl/phase_timer.sv
// Loadable countdown that stops at 1; done marks the final cycle of a phase.
module phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && cnt > W'(1)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));
endmodule

// File: rtl/pattern_sequencer.sv
// Stores a growing symbol sequence, plays it back on one-hot LEDs and checks
// the player's answer forward or reversed, with an optional per-input timeout.
module pattern_sequencer
    import memgame_pkg::*;
#(
    parameter int SYMBOL_W       = DEF_SYMBOL_W,
    parameter int MAX_LEN        = DEF_MAX_LEN,
    parameter int ON_CYCLES      = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int LEN_W          = $clog2(MAX_LEN + 1)
) (
    input logic               clk,
    input logic               rst_n,
    pattern_sequencer_if.slave sif
);
    localparam int LED_N = 2**SYMBOL_W;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int T_A   = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int T_MAX = (T_A > TIMEOUT_CYCLES) ? T_A : TIMEOUT_CYCLES;
    localparam int TMR_W = $clog2(T_MAX + 1);

    seq_state_t          state, state_n;
    logic [LEN_W-1:0]    len, len_n;
    logic [IDX_W-1:0]    idx, idx_n, ptr, ptr_n;
    logic                rev, rev_n;
    logic [LED_N-1:0]    led, led_n;
    logic                ok_q, ok_n, mis_q, mis_n, to_q, to_n;
    logic [SYMBOL_W-1:0] mem [MAX_LEN];
    logic                mem_we;
    logic                tmr_load, tmr_done;
    logic [TMR_W-1:0]    tmr_val;
    logic                len_full, last_idx, last_ptr;
    logic [IDX_W-1:0]    idx_inc;
    logic [SYMBOL_W-1:0] first_sym;

    assign len_full  = (len == LEN_W'(MAX_LEN));
    assign last_idx  = (LEN_W'(idx) == len - LEN_W'(1));
    assign last_ptr  = rev ? (ptr == '0) : (LEN_W'(ptr) == len - LEN_W'(1));
    assign idx_inc   = idx + IDX_W'(1);
    // Symbol 0 is the incoming rand_sym when the sequence is still empty.
    assign first_sym = (len == '0) ? sif.rand_sym : mem[0];

    always_comb begin
        state_n  = state;
        len_n    = len;
        idx_n    = idx;
        ptr_n    = ptr;
        rev_n    = rev;
        led_n    = led;
        ok_n     = 1'b0;
        mis_n    = 1'b0;
        to_n     = 1'b0;
        mem_we   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (sif.start) begin
                    rev_n    = sif.mode_reverse;
                    idx_n    = '0;
                    state_n  = SHOW_ON;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(ON_CYCLES);
                    led_n    = LED_N'(onehot(ONEHOT_MAX_W'(first_sym)));
                    if (!len_full) begin
                        mem_we = 1'b1;
                        len_n  = len + LEN_W'(1);
                    end
                end
            end
            SHOW_ON: begin
                if (tmr_done) begin
                    led_n    = '0;
                    state_n  = SHOW_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_CYCLES);
                end
            end
            SHOW_GAP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (last_idx) begin
                        state_n = COLLECT;
                        ptr_n   = rev ? IDX_W'(len - LEN_W'(1)) : '0;
                        tmr_val = TMR_W'(TIMEOUT_CYCLES);
                    end else begin
                        state_n = SHOW_ON;
                        idx_n   = idx_inc;
                        led_n   = LED_N'(onehot(ONEHOT_MAX_W'(mem[idx_inc])));
                        tmr_val = TMR_W'(ON_CYCLES);
                    end
                end
            end
            COLLECT: begin
                // A strobe in the expiry cycle is judged instead of timing out.
                if (sif.in_valid) begin
                    if (sif.in_sym == mem[ptr]) begin
                        if (last_ptr) begin
                            ok_n    = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ptr_n    = rev ? ptr - IDX_W'(1) : ptr + IDX_W'(1);
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(TIMEOUT_CYCLES);
                        end
                    end else begin
                        mis_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (TIMEOUT_CYCLES != 0 && tmr_done) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len   <= '0;
            idx   <= '0;
            ptr   <= '0;
            rev   <= 1'b0;
            led   <= '0;
            ok_q  <= 1'b0;
            mis_q <= 1'b0;
            to_q  <= 1'b0;
        end else if (sif.clear) begin
            state <= IDLE;
            len   <= '0;
            idx   <= '0;
            ptr   <= '0;
            rev   <= 1'b0;
            led   <= '0;
            ok_q  <= 1'b0;
            mis_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            state <= state_n;
            len   <= len_n;
            idx   <= idx_n;
            ptr   <= ptr_n;
            rev   <= rev_n;
            led   <= led_n;
            ok_q  <= ok_n;
            mis_q <= mis_n;
            to_q  <= to_n;
        end
    end

    // Sequence storage is never cleared; entries at or above len are unused.
    always_ff @(posedge clk) begin
        if (mem_we && !sif.clear) begin
            mem[IDX_W'(len)] <= sif.rand_sym;
        end
    end

    phase_timer #(.W(TMR_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sif.clear),
        .load  (tmr_load),
        .value (tmr_val),
        .en    (state != IDLE),
        .done  (tmr_done)
    );

    assign sif.led       = led;
    assign sif.busy      = (state != IDLE);
    assign sif.expecting = (state == COLLECT);
    assign sif.round_ok  = ok_q;
    assign sif.mismatch  = mis_q;
    assign sif.timeout   = to_q;
    assign sif.full      = len_full;
    assign sif.len       = len;
endmodule
